pcbfpga_cfg_loader: RTL and testbench

Configuration controller for the PCB-FPGA fabric. It takes a byte stream of configuration data (LUT INIT bits, routing bits) over a valid/ready interface and shifts exactly CHAIN_LEN bits into the board's serial configuration chain. It verifies a trailing XOR checksum and pulses the chain latch only on a match, so fabric configuration is applied atomically. It sits between the host or flash reader and the physical shift-register chain that drives the LUT/DFF/IO tiles.

---
 rtl/pcbfpga_cfg_pkg.sv | 21 ++
 rtl/pcbfpga_sck_gen.sv | 40 ++++
 rtl/pcbfpga_cfg_loader.sv | 163 ++++++++++++++++
 tb/tb_pcbfpga_cfg_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcbfpga_cfg_pkg.sv
// Shared definitions for the PCB-FPGA configuration loader.
//   state_t      : loader FSM states
//   CSUM_SEED    : initial value of the running XOR checksum
//   calc_nbytes  : number of data bytes needed to carry a chain of given length
package pcbfpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_CHECK,
        ST_LATCH
    } state_t;

    localparam logic [7:0] CSUM_SEED = 8'h00;

    function automatic int calc_nbytes(input int chain_len);
        return (chain_len + 7) / 8;
    endfunction

endpackage

// File: rtl/pcbfpga_sck_gen.sv
// Shift-clock generator for the configuration chain.
// Each bit period is CLK_DIV cycles low followed by CLK_DIV cycles high.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   en         : run the timer; when low the generator is held in reset (sck low)
//   sck        : chain shift clock, starts every bit in the low phase
//   end_of_bit : one-cycle strobe on the last cycle of the high phase
module pcbfpga_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic end_of_bit
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] PHASE_LAST = TW'(CLK_DIV - 1);

    logic [TW-1:0] timer;
    logic          phase;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            timer <= '0;
            phase <= 1'b0;
        end else if (timer == PHASE_LAST) begin
            timer <= '0;
            phase <= ~phase;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign sck        = phase;
    assign end_of_bit = en && phase && (timer == PHASE_LAST);

endmodule

// File: rtl/pcbfpga_cfg_loader.sv
// Configuration loader: accepts a byte stream over valid/ready, shifts
// CHAIN_LEN bits (LSB of each byte first) into the serial config chain,
// then compares one trailing byte against the XOR of all data bytes and
// pulses the chain latch only when they match.
// Ports:
//   CLK, RST   : clock and synchronous active-high reset
//   START      : begin a load (honoured only in IDLE)
//   IN_DATA    : configuration / checksum byte
//   IN_VALID   : IN_DATA valid
//   IN_READY   : byte accepted on IN_VALID & IN_READY (FETCH and CHECK only)
//   CFG_SDO    : serial data to the chain
//   CFG_SCK    : chain shift clock, idle low
//   CFG_LE     : chain latch enable, high CLK_DIV cycles after a good checksum
//   BUSY       : high outside IDLE
//   DONE, ERR  : sticky result of the last load (mutually exclusive)
module pcbfpga_cfg_loader
    import pcbfpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int CLK_DIV   = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic       CFG_SDO,
    output logic       CFG_SCK,
    output logic       CFG_LE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] LE_LAST = TW'(CLK_DIV - 1);

    state_t          state;
    state_t          state_next;
    logic [7:0]      shbuf;
    logic [7:0]      csum;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]      byte_bit;
    logic [TW-1:0]   le_timer;
    logic            done_q;
    logic            err_q;
    logic            end_of_bit;
    logic            shifting;

    assign shifting = (state == ST_SHIFT);

    // Timer is held in reset outside SHIFT, so SCK is low in every other state.
    pcbfpga_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk       (CLK),
        .rst       (RST),
        .en        (shifting),
        .sck       (CFG_SCK),
        .end_of_bit(end_of_bit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        IN_READY   = 1'b0;
        CFG_LE     = 1'b0;
        BUSY       = 1'b1;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (START) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Chain-length test wins so a partial final byte ends the shift.
                if (end_of_bit) begin
                    if (bit_cnt == LAST_BIT)    state_next = ST_CHECK;
                    else if (byte_bit == 3'd7)  state_next = ST_FETCH;
                end
            end
            ST_CHECK: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_next = (IN_DATA == csum) ? ST_LATCH : ST_IDLE;
            end
            ST_LATCH: begin
                CFG_LE = 1'b1;
                if (le_timer == LE_LAST) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shbuf    <= '0;
            csum     <= CSUM_SEED;
            bit_cnt  <= '0;
            byte_bit <= '0;
            le_timer <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        csum     <= CSUM_SEED;
                        bit_cnt  <= '0;
                        byte_bit <= '0;
                    end
                end
                ST_FETCH: begin
                    if (IN_VALID) begin
                        shbuf    <= IN_DATA;
                        csum     <= csum ^ IN_DATA;
                        byte_bit <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (end_of_bit) begin
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        byte_bit <= byte_bit + 3'd1;
                        shbuf    <= {1'b0, shbuf[7:1]};
                    end
                end
                ST_CHECK: begin
                    le_timer <= '0;
                    if (IN_VALID && (IN_DATA != csum)) err_q <= 1'b1;
                end
                ST_LATCH: begin
                    if (le_timer == LE_LAST) begin
                        le_timer <= '0;
                        done_q   <= 1'b1;
                    end else begin
                        le_timer <= le_timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next bit is already at shbuf[0] when the low phase of its period starts.
    assign CFG_SDO = shbuf[0];
    assign DONE    = done_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_pcbfpga_cfg_loader.sv
// Bench for pcbfpga_cfg_loader with CHAIN_LEN=12; one instance with CLK_DIV=1
// and one with CLK_DIV=3, selected by 'sel'. Expected SDO bits are queued when
// a byte is driven and popped at each observed SCK rise.
module tb_pcbfpga_cfg_loader;
    import pcbfpga_cfg_pkg::*;

    localparam int CHAIN = 12;
    localparam int NB    = calc_nbytes(CHAIN);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       sel = 1'b0;

    logic rdy1, sdo1, sck1, le1, busy1, done1, err1;
    logic rdy3, sdo3, sck3, le3, busy3, done3, err3;
    logic start1, start3;

    assign start1 = start & ~sel;
    assign start3 = start & sel;

    pcbfpga_cfg_loader #(.CHAIN_LEN(CHAIN), .CLK_DIV(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(rdy1), .CFG_SDO(sdo1), .CFG_SCK(sck1), .CFG_LE(le1),
        .BUSY(busy1), .DONE(done1), .ERR(err1)
    );

    pcbfpga_cfg_loader #(.CHAIN_LEN(CHAIN), .CLK_DIV(3)) dut3 (
        .CLK(clk), .RST(rst), .START(start3), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(rdy3), .CFG_SDO(sdo3), .CFG_SCK(sck3), .CFG_LE(le3),
        .BUSY(busy3), .DONE(done3), .ERR(err3)
    );

    logic ready, sdo, sck, le, busy, done, err;
    assign ready = sel ? rdy3  : rdy1;
    assign sdo   = sel ? sdo3  : sdo1;
    assign sck   = sel ? sck3  : sck1;
    assign le    = sel ? le3   : le1;
    assign busy  = sel ? busy3 : busy1;
    assign done  = sel ? done3 : done1;
    assign err   = sel ? err3  : err1;

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] cs;
        int         gap;
        logic       sel;
        logic       exp_done;
        logic       exp_err;
        int         exp_le;
    } vec_t;

    vec_t vecs[6];
    logic exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   rise_total = 0;
    int   le_total = 0;
    int   hi_run = 0;
    int   div_cur = 1;
    logic sck_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and observe the selected DUT #1 after the edge.
    task automatic tick();
        logic e;
        @(posedge clk);
        #1;
        if (sck && !sck_prev) begin
            rise_total++;
            if (exp_q.size() == 0) begin
                check("sdo_extra_rise", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sdo_bit", sdo, e);
            end
        end
        if (!sck && sck_prev) check("sck_high_len", hi_run, div_cur);
        hi_run = sck ? (sck_prev ? hi_run + 1 : 1) : 0;
        if (le) le_total++;
        if (ready) check("sck_low_while_ready", sck, 0);
        sck_prev = sck;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap, input bit push, input int idx);
        int k;
        int nbits;
        if (push) begin
            nbits = (CHAIN - 8 * idx > 8) ? 8 : CHAIN - 8 * idx;
            for (int i = 0; i < nbits; i++) exp_q.push_back(d[i]);
        end
        repeat (gap) tick();
        in_data  = d;
        in_valid = 1'b1;
        k = 0;
        while (!ready && k < 200) begin
            tick();
            k++;
        end
        if (!ready) check("ready_timeout", ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 1000) begin
            tick();
            k++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        int le0;
        int r0;
        sel     = v.sel;
        div_cur = v.sel ? 3 : 1;
        le0 = le_total;
        r0  = rise_total;
        pulse_start();
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
        check("err_cleared", err, 0);
        send_byte(v.b0, v.gap, 1'b1, 0);
        send_byte(v.b1, v.gap, 1'b1, 1);
        send_byte(v.cs, v.gap, 1'b0, NB);
        wait_idle();
        check("done", done, v.exp_done);
        check("err", err, v.exp_err);
        check("le_cycles", le_total - le0, v.exp_le);
        check("sck_rises", rise_total - r0, CHAIN);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int le0;
        int r0;
        int k;

        vecs[0] = '{8'hA5, 8'h0F, 8'hAA, 0, 1'b0, 1'b1, 1'b0, 1};
        vecs[1] = '{8'hA5, 8'h0F, 8'h00, 0, 1'b0, 1'b0, 1'b1, 0};
        vecs[2] = '{8'hA5, 8'h0F, 8'hAA, 5, 1'b0, 1'b1, 1'b0, 1};
        vecs[3] = '{8'h3C, 8'hF0, 8'hCC, 2, 1'b0, 1'b1, 1'b0, 1};
        vecs[4] = '{8'hA5, 8'h0F, 8'hAA, 0, 1'b1, 1'b1, 1'b0, 3};
        vecs[5] = '{8'hA5, 8'h0F, 8'h55, 1, 1'b1, 1'b0, 1'b1, 0};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_outputs", {ready, sdo, sck, le, busy, done, err}, 0);
        tick();
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("valid_ignored_in_idle", {ready, busy}, 0);

        for (int i = 0; i < 6; i++) run_load(vecs[i]);

        // START during SHIFT is ignored; a new START after DONE clears it.
        sel = 1'b0;
        div_cur = 1;
        le0 = le_total;
        r0  = rise_total;
        pulse_start();
        send_byte(8'hA5, 0, 1'b1, 0);
        pulse_start();
        send_byte(8'h0F, 0, 1'b1, 1);
        send_byte(8'hAA, 0, 1'b0, NB);
        wait_idle();
        check("mid_start_done", done, 1);
        check("mid_start_rises", rise_total - r0, CHAIN);
        check("mid_start_le", le_total - le0, 1);
        repeat (4) tick();
        check("mid_start_no_reload", busy, 0);
        pulse_start();
        check("restart_done_clear", done, 0);
        check("restart_busy", busy, 1);
        send_byte(8'hA5, 0, 1'b1, 0);
        send_byte(8'h0F, 0, 1'b1, 1);
        send_byte(8'hAA, 0, 1'b0, NB);
        wait_idle();
        check("restart_done", done, 1);

        // Reset after the 5th SCK rise aborts the load without a latch pulse.
        le0 = le_total;
        r0  = rise_total;
        pulse_start();
        send_byte(8'hA5, 0, 1'b1, 0);
        k = 0;
        while (rise_total < r0 + 5 && k < 200) begin
            tick();
            k++;
        end
        check("abort_reached_rise5", rise_total - r0, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", {ready, sdo, sck, le, busy, done, err}, 0);
        exp_q.delete();
        repeat (6) tick();
        check("abort_stays_idle", busy, 0);
        check("abort_no_le", le_total - le0, 0);
        run_load(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
